// File: rtl/mdu_hilo_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, default
// latencies and FSM state encoding.
package mdu_hilo_pkg;

    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MTHI  = 3'd4;
    localparam logic [2:0] MDU_MTLO  = 3'd5;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mdu_state_e;

endpackage

// File: rtl/mdu_arith.sv
// Combinational arithmetic core: signed/unsigned 32x32 product and
// quotient/remainder, packed as {hi, lo}.
module mdu_arith
    import mdu_hilo_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] result,
    output logic        div_by_zero
);

    logic [63:0] prod_s_s;
    logic [63:0] prod_u_s;
    logic [31:0] dvd_s;
    logic [31:0] dvs_s;
    logic [31:0] q_mag_s;
    logic [31:0] r_mag_s;
    logic [31:0] q_s;
    logic [31:0] r_s;
    logic        is_signed_s;
    logic        neg_q_s;
    logic        neg_r_s;

    // Products, sign-magnitude division and result selection
    always_comb begin
        prod_u_s    = {32'd0, a} * {32'd0, b};
        prod_s_s    = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        is_signed_s = (op == MDU_DIV);
        neg_r_s     = is_signed_s & a[31];
        neg_q_s     = is_signed_s & (a[31] ^ b[31]);
        dvd_s       = neg_r_s ? (32'd0 - a) : a;
        dvs_s       = (is_signed_s & b[31]) ? (32'd0 - b) : b;
        div_by_zero = ((op == MDU_DIV) || (op == MDU_DIVU)) && (b == 32'd0);

        // 0x80000000 as a magnitude is 2^31, so the overflow case wraps back to itself
        if (dvs_s == 32'd0) begin
            q_mag_s = 32'd0;
            r_mag_s = 32'd0;
        end else begin
            q_mag_s = dvd_s / dvs_s;
            r_mag_s = dvd_s % dvs_s;
        end
        q_s = neg_q_s ? (32'd0 - q_mag_s) : q_mag_s;
        r_s = neg_r_s ? (32'd0 - r_mag_s) : r_mag_s;

        case (op)
            MDU_MULT:          result = prod_s_s;
            MDU_MULTU:         result = prod_u_s;
            MDU_DIV, MDU_DIVU: result = {r_s, q_s};
            default:           result = 64'd0;
        endcase
    end

endmodule

// File: rtl/mdu_hilo.sv
// Multiply/divide unit with HI/LO registers; multi-cycle latency is modelled
// by a down-counter and a registered busy flag used by the stall logic.
module mdu_hilo
    import mdu_hilo_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [31:0] MULT_N = 32'(MULT_CYCLES);
    localparam logic [31:0] DIV_N  = 32'(DIV_CYCLES);

    mdu_state_e  state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] res_hi_q, res_hi_d;
    logic [31:0] res_lo_q, res_lo_d;
    logic        dbz_q, dbz_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [63:0] arith_res_s;
    logic        arith_dbz_s;

    mdu_arith u_arith (
        .op          (op),
        .a           (a),
        .b           (b),
        .result      (arith_res_s),
        .div_by_zero (arith_dbz_s)
    );

    // Next-state logic for FSM, counter, staging and HI/LO
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        dbz_d    = dbz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    case (op)
                        MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
                            state_d  = BUSY;
                            busy_d   = 1'b1;
                            cnt_d    = ((op == MDU_MULT) || (op == MDU_MULTU)) ? MULT_N : DIV_N;
                            res_hi_d = arith_res_s[63:32];
                            res_lo_d = arith_res_s[31:0];
                            dbz_d    = arith_dbz_s;
                        end
                        MDU_MTHI: hi_d = a;
                        MDU_MTLO: lo_d = a;
                        default:  state_d = IDLE;
                    endcase
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                // Requests arriving here are dropped; upstream holds them until busy falls
                if (cnt_q == 32'd1) begin
                    state_d = IDLE;
                    cnt_d   = 32'd0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    if (!dbz_q) begin
                        hi_d = res_hi_q;
                        lo_d = res_lo_q;
                    end else begin
                        hi_d = hi_q;
                        lo_d = lo_q;
                    end
                end else begin
                    cnt_d  = cnt_q - 32'd1;
                    busy_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 32'd0;
            res_hi_q <= 32'd0;
            res_lo_q <= 32'd0;
            dbz_q    <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            dbz_q    <= dbz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: doc/mdu_hilo.md
Name: mdu_hilo

Overview:
- Multiply/divide unit with HI/LO registers, directly downstream of the general register file.
- Consumes the two GRF read ports (rs, rt) and executes mult/multu/div/divu/mthi/mtlo.
- Exposes HI/LO to the writeback mux for mfhi/mflo.
- Models multi-cycle latency with a busy flag, which the hazard/stall logic uses to freeze the front end.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (>=1)
- DIV_CYCLES, 10, busy cycles for div/divu (>=1)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, synchronous, active-high
- start  input  1  operation request, sampled at rising edge
- op  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6/7 reserved
- a  input  32  rs operand (GRF rd1)
- b  input  32  rt operand (GRF rd2)
- busy  output  1  arithmetic op in progress
- done  output  1  one-cycle pulse when HI/LO take an arithmetic result
- hi  output  32  HI register
- lo  output  32  LO register

Behaviour:
- Reset values:
  - hi=0, lo=0, busy=0, done=0.
  - Counter and staging registers cleared; state IDLE.
- States:
  - IDLE: busy=0.
  - BUSY: busy=1, down-counter cnt active.
- IDLE, start=1, op 0..3 at edge T:
  - Compute result into staging registers res_hi/res_lo.
  - Load cnt = MULT_CYCLES (op 0,1) or DIV_CYCLES (op 2,3); go to BUSY.
  - busy=1 for cycles T+1 .. T+N.
- BUSY, each edge: cnt decrements.
- Edge where cnt==1:
  - hi<=res_hi, lo<=res_lo (subject to the divide-by-zero rule).
  - Return to IDLE; done=1 for exactly that next cycle.
  - Result is visible with busy=0 in cycle T+N+1.
- IDLE, start=1, op 4 (mthi): hi<=a at that edge, lo unchanged. Op 5 (mtlo): lo<=a, hi unchanged. No busy, no done.
- Reserved ops 6/7: no effect.
- start while busy: ignored for every op, including mthi/mtlo. Upstream stall logic must hold the instruction until busy=0.
- mult: signed 32x32 -> 64-bit product; hi = bits 63:32, lo = bits 31:0.
- multu: unsigned product; same split.
- div:
  - Signed; lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- divu: unsigned quotient in lo, remainder in hi.
- Divide by zero (b==0, op 2/3):
  - Full DIV_CYCLES busy and done pulse still occur.
  - hi/lo retain their prior values.
- Reset mid-operation: returns to IDLE immediately at that edge, hi/lo=0, staging discarded, no done pulse.
- rst has priority over start.
- Operands are sampled only at the start edge; later changes on a/b have no effect.
- hi/lo are driven straight from registers, so an mfhi/mflo read has no combinational path from a/b.

Decomposition:
- Shared package holds:
  - op encodings (MDU_MULT..MDU_MTLO)
  - default MULT_CYCLES/DIV_CYCLES
  - state encoding IDLE/BUSY
- One sub-module is natural: mdu_arith, a purely combinational block.
  - Inputs: op, a, b.
  - Outputs: 64-bit result and div_by_zero flag.
  - Covers signed/unsigned product and quotient/remainder, including the overflow corner.
- mdu_hilo keeps the FSM, counter, staging and HI/LO registers.

Test Plan:
- mult a=0xFFFFFFFF, b=0x00000002 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE, done pulse 1 cycle. multu with same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- div a=0xFFFFFFF9 (-7), b=2 -> busy 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu a=7, b=2 -> lo=3, hi=1. div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- mthi a=0x12345678 then mtlo a=0x9ABCDEF0 on consecutive cycles -> hi/lo updated the edge of each request, busy stays 0, no done; then div b=0 -> busy 10 cycles, done pulses, hi=0x12345678 and lo=0x9ABCDEF0 unchanged.
- Start mult 3*4, then during busy assert start with div 100/7 and mthi 0xDEAD -> both ignored; final hi=0, lo=12 after exactly 5 busy cycles.
- After hi=5, lo=6 via mthi/mtlo, start divu 9/2 and assert rst in busy cycle 3 -> next cycle busy=0, hi=0, lo=0; done stays 0 for the following 10 cycles.
- MULT_CYCLES=1 instance: mult 0xFFFF*0xFFFF -> busy exactly 1 cycle, then lo=0xFFFE0001, hi=0; back-to-back start accepted on the first busy=0 cycle.
